// File: rtl/decode_stage_pkg.sv
// Shared processor package: opcode constants, ALU function codes, stack-op
// encodings and a small helper used by the decode logic.
//   Opcode constants  : Op* (IR[7:4])
//   alu_op_e          : ALU function code driven to execute
//   stack_op_e        : 0 none, 1 push, 2 pop
package decode_stage_pkg;

    localparam logic [3:0] OpNop     = 4'd0;
    localparam logic [3:0] OpMov     = 4'd1;
    localparam logic [3:0] OpAdd     = 4'd2;
    localparam logic [3:0] OpSub     = 4'd3;
    localparam logic [3:0] OpAnd     = 4'd4;
    localparam logic [3:0] OpOr      = 4'd5;
    localparam logic [3:0] OpShift   = 4'd6;
    localparam logic [3:0] OpStack   = 4'd7;
    localparam logic [3:0] OpUnary   = 4'd8;
    localparam logic [3:0] OpJcc     = 4'd9;
    localparam logic [3:0] OpLoop    = 4'd10;
    localparam logic [3:0] OpBranch  = 4'd11;
    localparam logic [3:0] OpMem     = 4'd12;
    localparam logic [3:0] OpLdi     = 4'd13;
    localparam logic [3:0] OpSti     = 4'd14;
    localparam logic [3:0] OpIllegal = 4'd15;

    typedef enum logic [3:0] {
        AluNone = 4'd0,
        AluMov  = 4'd1,
        AluAdd  = 4'd2,
        AluSub  = 4'd3,
        AluAnd  = 4'd4,
        AluOr   = 4'd5,
        AluRlc  = 4'd6,
        AluRrc  = 4'd7,
        AluSetc = 4'd8,
        AluClrc = 4'd9,
        AluNot  = 4'd10,
        AluInc  = 4'd11,
        AluDec  = 4'd12,
        AluNeg  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        StackNone = 2'd0,
        StackPush = 2'd1,
        StackPop  = 2'd2
    } stack_op_e;

    // Branch-type opcodes expose their condition/sub-op field on brx.
    function automatic logic is_branch(input logic [3:0] op);
        return (op == OpJcc) || (op == OpBranch);
    endfunction

endpackage

// File: rtl/decode_table.sv
// Combinational instruction decode table.
//   valid_i       : held instruction present; all outputs forced to 0 when low
//   ir_i, imm_i   : held instruction byte and second byte
//   opcode_o..rb_o: IR fields; brx_o = ra for branch opcodes
//   imm_o         : imm_i for two-byte instructions, else 0
//   control outs  : two_byte, alu_op, reg_write, mem_read, mem_write, stack_op, illegal
module decode_table
    import decode_stage_pkg::*;
(
    input  logic       valid_i,
    input  logic [7:0] ir_i,
    input  logic [7:0] imm_i,
    output logic [3:0] opcode_o,
    output logic [1:0] ra_o,
    output logic [1:0] rb_o,
    output logic [1:0] brx_o,
    output logic [7:0] imm_o,
    output logic       two_byte_o,
    output logic [3:0] alu_op_o,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic [1:0] stack_op_o,
    output logic       illegal_o
);

    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    alu_op_e    alu;
    stack_op_e  stk;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       ill;
    logic       two;

    assign op = ir_i[7:4];
    assign ra = ir_i[3:2];
    assign rb = ir_i[1:0];

    always_comb begin
        alu = AluNone;
        stk = StackNone;
        rw  = 1'b0;
        mr  = 1'b0;
        mw  = 1'b0;
        ill = 1'b0;
        two = 1'b0;
        unique case (op)
            OpNop:   ;
            OpMov:   begin rw = 1'b1; alu = AluMov; end
            OpAdd:   begin rw = 1'b1; alu = AluAdd; end
            OpSub:   begin rw = 1'b1; alu = AluSub; end
            OpAnd:   begin rw = 1'b1; alu = AluAnd; end
            OpOr:    begin rw = 1'b1; alu = AluOr;  end
            OpShift: begin
                unique case (ra)
                    2'd0: alu = AluRlc;
                    2'd1: alu = AluRrc;
                    2'd2: alu = AluSetc;
                    2'd3: alu = AluClrc;
                endcase
            end
            OpStack: begin
                unique case (ra)
                    2'd0: stk = StackPush;
                    2'd1: begin stk = StackPop; rw = 1'b1; end
                    2'd2: ;                  // OUT
                    2'd3: rw = 1'b1;         // IN
                endcase
            end
            OpUnary: begin
                rw = 1'b1;
                unique case (ra)
                    2'd0: alu = AluNot;
                    2'd1: alu = AluInc;
                    2'd2: alu = AluDec;
                    2'd3: alu = AluNeg;
                endcase
            end
            OpJcc:   ;
            OpLoop:  begin rw = 1'b1; alu = AluDec; end
            OpBranch: begin
                unique case (ra)
                    2'd0: ;                  // JMP
                    2'd1: stk = StackPush;   // CALL
                    2'd2: stk = StackPop;    // RET
                    2'd3: stk = StackPop;    // RTI
                endcase
            end
            OpMem: begin
                two = 1'b1;
                unique case (ra)
                    2'd0: rw = 1'b1;                      // LDM
                    2'd1: begin mr = 1'b1; rw = 1'b1; end // LDD
                    2'd2: mw = 1'b1;                      // STD
                    2'd3: ;
                endcase
            end
            OpLdi:     begin mr = 1'b1; rw = 1'b1; end
            OpSti:     mw = 1'b1;
            OpIllegal: ill = 1'b1;
        endcase
    end

    always_comb begin
        opcode_o    = '0;
        ra_o        = '0;
        rb_o        = '0;
        brx_o       = '0;
        imm_o       = '0;
        two_byte_o  = 1'b0;
        alu_op_o    = '0;
        reg_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        stack_op_o  = '0;
        illegal_o   = 1'b0;
        if (valid_i) begin
            opcode_o    = op;
            ra_o        = ra;
            rb_o        = rb;
            brx_o       = is_branch(op) ? ra : 2'd0;
            imm_o       = two ? imm_i : 8'd0;
            two_byte_o  = two;
            alu_op_o    = alu;
            reg_write_o = rw;
            mem_read_o  = mr;
            mem_write_o = mw;
            stack_op_o  = stk;
            illegal_o   = ill;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: output register (OR) plus a one-entry skid buffer
// in front of the combinational decode table.
//   clk, reset          : clock, synchronous active-high reset
//   IR, IMM, instr_done : instruction bytes from fetch, valid when instr_done=1
//   stall, flush        : hold request from execute / discard pending work
//   valid..illegal      : decoded fields of the held instruction
//   overflow            : sticky, set when an instruction is lost to a full skid
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [7:0] IMM,
    input  logic       instr_done,
    input  logic       stall,
    input  logic       flush,
    output logic       valid,
    output logic [3:0] opcode,
    output logic [1:0] ra,
    output logic [1:0] rb,
    output logic [1:0] brx,
    output logic [7:0] imm_out,
    output logic       two_byte,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] stack_op,
    output logic       illegal,
    output logic       overflow
);

    logic       valid_q, valid_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] imm_q, imm_d;
    logic       skid_valid_q, skid_valid_d;
    logic [7:0] skid_ir_q, skid_ir_d;
    logic [7:0] skid_imm_q, skid_imm_d;
    logic       overflow_q, overflow_d;

    always_comb begin
        valid_d      = valid_q;
        ir_d         = ir_q;
        imm_d        = imm_q;
        skid_valid_d = skid_valid_q;
        skid_ir_d    = skid_ir_q;
        skid_imm_d   = skid_imm_q;
        overflow_d   = overflow_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (stall) begin
            // OR frozen; incoming work goes to the skid or is lost.
            if (instr_done) begin
                if (!skid_valid_q) begin
                    skid_valid_d = 1'b1;
                    skid_ir_d    = IR;
                    skid_imm_d   = IMM;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (skid_valid_q) begin
            // Older skid entry first; a same-cycle arrival takes its place.
            valid_d      = 1'b1;
            ir_d         = skid_ir_q;
            imm_d        = skid_imm_q;
            skid_valid_d = instr_done;
            if (instr_done) begin
                skid_ir_d  = IR;
                skid_imm_d = IMM;
            end
        end else if (instr_done) begin
            valid_d = 1'b1;
            ir_d    = IR;
            imm_d   = IMM;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            ir_q         <= '0;
            imm_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_ir_q    <= '0;
            skid_imm_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            ir_q         <= ir_d;
            imm_q        <= imm_d;
            skid_valid_q <= skid_valid_d;
            skid_ir_q    <= skid_ir_d;
            skid_imm_q   <= skid_imm_d;
            overflow_q   <= overflow_d;
        end
    end

    assign valid    = valid_q;
    assign overflow = overflow_q;

    decode_table u_decode_table (
        .valid_i     (valid_q),
        .ir_i        (ir_q),
        .imm_i       (imm_q),
        .opcode_o    (opcode),
        .ra_o        (ra),
        .rb_o        (rb),
        .brx_o       (brx),
        .imm_o       (imm_out),
        .two_byte_o  (two_byte),
        .alu_op_o    (alu_op),
        .reg_write_o (reg_write),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .stack_op_o  (stack_op),
        .illegal_o   (illegal)
    );

endmodule
